// File: rtl/wb_common_pkg.sv
// Shared Wishbone B3 encodings, FSM state type and the burst address helper.
package wb_common_pkg;

   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_INC     = 3'b010;
   localparam logic [2:0] CTI_EOB     = 3'b111;

   localparam logic [1:0] BTE_LINEAR  = 2'b00;
   localparam logic [1:0] BTE_WRAP4   = 2'b01;
   localparam logic [1:0] BTE_WRAP8   = 2'b10;
   localparam logic [1:0] BTE_WRAP16  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CLASSIC,
      ST_BURST
   } wb_state_e;

   // Next byte address of an incrementing burst. Wrapping bursts only advance
   // the word bits inside the wrap window and hold everything above it.
   // Non-incrementing cycle types do not advance.
   function automatic logic [31:0] wb_next_adr(input logic [31:0] adr,
                                               input logic [2:0]  cti,
                                               input logic [1:0]  bte);
      logic [31:0] inc;
      inc = adr + 32'd4;
      if (cti != CTI_INC) return adr;
      case (bte)
         BTE_LINEAR: return inc;
         BTE_WRAP4:  return {adr[31:4], inc[3:2], adr[1:0]};
         BTE_WRAP8:  return {adr[31:5], inc[4:2], adr[1:0]};
         BTE_WRAP16: return {adr[31:6], inc[5:2], adr[1:0]};
         default:    return inc;
      endcase
   endfunction

endpackage

// File: rtl/wb_ram_sp.sv
// Single-port synchronous word RAM with byte-lane write enables and a
// registered read. A write cycle does not update the read register.
module wb_ram_sp #(
   parameter int unsigned WORDS   = 8192,
   parameter int unsigned WAW     = 13,
   parameter string       MEMFILE = ""
) (
   input  logic            clk,
   input  logic [3:0]      we,
   input  logic [WAW-1:0]  adr,
   input  logic [31:0]     wdat,
   output logic [31:0]     rdat
);

   logic [31:0] mem [0:WORDS-1];

   // Lane writes, or a registered read when no lane is written.
   always_ff @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
         if (we[b]) mem[adr][8*b +: 8] <= wdat[8*b +: 8];
      end
      if (we == 4'b0000) rdat <= mem[adr];
   end

endmodule

// File: rtl/wb_ram_burst.sv
// Wishbone B3 slave RAM: classic and registered-feedback incrementing bursts
// (linear, wrap4/8/16), byte-lane writes, err on out-of-range addresses.
module wb_ram_burst
   import wb_common_pkg::*;
#(
   parameter int unsigned MEM_SIZE = 32'h0000_8000,
   parameter string       MEMFILE  = ""
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_ni,
   input  logic [31:0] wb_adr_i,
   input  logic [31:0] wb_dat_i,
   input  logic [3:0]  wb_sel_i,
   input  logic        wb_we_i,
   input  logic        wb_cyc_i,
   input  logic        wb_stb_i,
   input  logic [2:0]  wb_cti_i,
   input  logic [1:0]  wb_bte_i,
   output logic [31:0] wb_dat_o,
   output logic        wb_ack_o,
   output logic        wb_err_o
);

   localparam int unsigned AW = $clog2(MEM_SIZE);

   wb_state_e   state;
   logic [31:0] cur_adr;   // address of the beat currently being terminated
   logic [31:0] nxt_adr;
   logic [31:0] issue_adr;
   logic        ack_q;
   logic        err_q;
   logic [31:0] dat_hold;
   logic [31:0] ram_q;
   logic        req;
   logic        beat_done;
   logic        wr_beat;
   logic [3:0]  ram_we;
   logic [AW-3:0] ram_adr;

   assign req       = wb_cyc_i & wb_stb_i;
   assign beat_done = ack_q & req;
   assign wr_beat   = beat_done & wb_we_i;
   assign nxt_adr   = wb_next_adr(cur_adr, wb_cti_i, wb_bte_i);

   // Terminations are gated by the live request so they drop in the same
   // cycle stb/cyc go low; read data holds its last value outside acks.
   assign wb_ack_o = ack_q & req;
   assign wb_err_o = err_q & req;
   assign wb_dat_o = wb_ack_o ? ram_q : dat_hold;

   // RAM port steering: a completing write beat owns the port, otherwise the
   // word for the next termination is read so it is ready with its ack.
   // The port is single, so a read beat directly following a write beat in
   // the same burst is not prefetched.
   always_comb begin
      issue_adr = cur_adr;
      if (state == ST_IDLE)
         issue_adr = wb_adr_i;
      else if (state == ST_BURST && beat_done && wb_cti_i == CTI_INC)
         issue_adr = nxt_adr;
      ram_we  = wr_beat ? wb_sel_i : 4'b0000;
      ram_adr = wr_beat ? cur_adr[AW-1:2] : issue_adr[AW-1:2];
   end

   wb_ram_sp #(
      .WORDS   (MEM_SIZE / 4),
      .WAW     (AW - 2),
      .MEMFILE (MEMFILE)
   ) ram0 (
      .clk  (wb_clk_i),
      .we   (ram_we),
      .adr  (ram_adr),
      .wdat (wb_dat_i),
      .rdat (ram_q)
   );

   // Transfer FSM: burst address tracking, range check and terminations.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state    <= ST_IDLE;
         cur_adr  <= '0;
         ack_q    <= 1'b0;
         err_q    <= 1'b0;
         dat_hold <= '0;
      end else begin
         ack_q <= 1'b0;
         err_q <= 1'b0;
         if (beat_done) dat_hold <= ram_q;
         case (state)
            ST_IDLE: begin
               if (req) begin
                  cur_adr <= wb_adr_i;
                  if (wb_adr_i >= MEM_SIZE) begin
                     err_q <= 1'b1;
                     state <= ST_CLASSIC;
                  end else begin
                     ack_q <= 1'b1;
                     state <= (wb_cti_i == CTI_INC) ? ST_BURST : ST_CLASSIC;
                  end
               end
            end
            // Single termination cycle (also used for burst err), then idle.
            ST_CLASSIC: state <= ST_IDLE;
            ST_BURST: begin
               if (!wb_cyc_i) begin
                  state <= ST_IDLE;
               end else if (!wb_stb_i) begin
                  // Wait state: beat not taken, address held.
               end else if (!ack_q) begin
                  ack_q <= 1'b1;          // resume at held address
               end else if (wb_cti_i == CTI_INC) begin
                  cur_adr <= nxt_adr;
                  if (nxt_adr >= MEM_SIZE) begin
                     err_q <= 1'b1;
                     state <= ST_CLASSIC;
                  end else begin
                     ack_q <= 1'b1;
                  end
               end else begin
                  state <= ST_IDLE;       // end-of-burst beat completed
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wb_ram_burst.sv
// Scoreboard bench for wb_ram_burst: drivers push expected terminations,
// a negedge monitor pops and compares them.
module tb_wb_ram_burst;
   import wb_common_pkg::*;

   localparam int unsigned MSZ = 32'h0000_8000;

   logic        clk;
   logic        rst_n;
   logic [31:0] adr, wdat, rdat;
   logic [3:0]  sel;
   logic        we, cyc, stb, ack, err;
   logic [2:0]  cti;
   logic [1:0]  bte;

   typedef struct {
      logic        is_err;
      logic        chk;
      logic [31:0] dat;
   } exp_t;

   exp_t        sbq[$];
   exp_t        mon_e;
   logic [31:0] mdl [0:8191];
   int          nerr = 0;
   int          ncheck = 0;

   wb_ram_burst #(.MEM_SIZE(MSZ), .MEMFILE("")) dut (
      .wb_clk_i  (clk),
      .wb_rst_ni (rst_n),
      .wb_adr_i  (adr),
      .wb_dat_i  (wdat),
      .wb_sel_i  (sel),
      .wb_we_i   (we),
      .wb_cyc_i  (cyc),
      .wb_stb_i  (stb),
      .wb_cti_i  (cti),
      .wb_bte_i  (bte),
      .wb_dat_o  (rdat),
      .wb_ack_o  (ack),
      .wb_err_o  (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncheck++;
      if (obs !== exp) begin
         nerr++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // Independent wrap arithmetic: window of 16/32/64 bytes by mask.
   function automatic logic [31:0] tnext(input logic [31:0] a, input logic [1:0] b);
      logic [31:0] w;
      if (b == 2'b00) return a + 32'd4;
      w = 32'd8 << b;
      return (a & ~(w - 1)) | ((a + 32'd4) & (w - 1));
   endfunction

   task automatic push_beat(input logic [31:0] a, input logic w, input logic [31:0] d,
                            input logic [3:0] s, output logic oob);
      exp_t e;
      logic [12:0] ix;
      oob = (a >= MSZ);
      ix = a[14:2];
      e.is_err = oob;
      e.chk = !oob && !w;
      e.dat = oob ? 32'h0 : mdl[ix];
      if (!oob && w)
         for (int b = 0; b < 4; b++) if (s[b]) mdl[ix][8*b +: 8] = d[8*b +: 8];
      sbq.push_back(e);
   endtask

   // Monitor: every termination must match the oldest expectation.
   always @(negedge clk) begin
      if (rst_n && (ack || err)) begin
         chk("ack_err_excl", {31'd0, ack & err}, 32'd0);
         if (sbq.size() == 0) begin
            chk("unexpected_term", 32'd1, 32'd0);
         end else begin
            mon_e = sbq.pop_front();
            chk("term_is_err", {31'd0, err}, {31'd0, mon_e.is_err});
            if (mon_e.chk && !err) chk("rdata", rdat, mon_e.dat);
         end
      end
   end

   task automatic idle_bus();
      cyc = 0; stb = 0; we = 0; cti = CTI_CLASSIC; bte = BTE_LINEAR;
   endtask

   // Classic access with fixed one-cycle latency; called just after a posedge.
   task automatic classic(input logic [31:0] a, input logic w, input logic [31:0] d,
                          input logic [3:0] s);
      logic oob;
      exp_t e;
      push_beat(a, w, d, s, oob);
      e = sbq[sbq.size()-1];
      cyc = 1; stb = 1; we = w; adr = a; wdat = d; sel = s; cti = CTI_CLASSIC;
      @(negedge clk) chk("cl_no_comb_term", {31'd0, ack | err}, 32'd0);
      @(posedge clk); #1;
      @(negedge clk) begin
         chk("cl_ack", {31'd0, ack}, {31'd0, !oob});
         chk("cl_err", {31'd0, err}, {31'd0, oob});
      end
      @(posedge clk); #1;
      idle_bus();
      @(negedge clk) begin
         chk("cl_gap", {31'd0, ack | err}, 32'd0);
         if (e.chk) chk("cl_dat_hold", rdat, e.dat);
      end
      @(posedge clk); #1;
   endtask

   // Incrementing burst of n beats; stb drops for gap_len cycles after
   // beat gap_after. Later beats drive a bogus address that must be ignored.
   task automatic burst(input logic [31:0] a0, input logic [1:0] b, input int n,
                        input logic w, input logic [31:0] dbase, input logic [3:0] s,
                        input int gap_after, input int gap_len);
      logic [31:0] a;
      logic oob, done, seen, was_err;
      int i, cnt;
      a = a0;
      for (int k = 0; k < n; k++) begin
         push_beat(a, w, dbase + k, s, oob);
         if (oob) break;
         a = tnext(a, b);
      end
      cyc = 1; stb = 1; we = w; adr = a0; wdat = dbase; sel = s; bte = b;
      cti = (n == 1) ? CTI_EOB : CTI_INC;
      i = 0; done = 0;
      while (!done) begin
         seen = 0; cnt = 0; was_err = 0;
         while (!seen && cnt < 16) begin
            @(negedge clk);
            if (ack || err) begin seen = 1; was_err = err; end
            else cnt++;
            if (!seen) begin @(posedge clk); #1; end
         end
         if (!seen) begin
            chk("burst_timeout", 32'd1, 32'd0);
            done = 1;
         end else begin
            @(posedge clk); #1;
            i++;
            if (was_err || i == n) done = 1;
            else begin
               adr = 32'hFFFF_FFF0;
               wdat = dbase + i;
               cti = (i == n - 1) ? CTI_EOB : CTI_INC;
               if (i == gap_after) begin
                  stb = 0;
                  repeat (gap_len) begin
                     @(negedge clk) chk("gap_ack_low", {31'd0, ack | err}, 32'd0);
                     @(posedge clk); #1;
                  end
                  stb = 1;
               end
            end
         end
      end
      idle_bus();
      @(negedge clk) chk("burst_end_idle", {31'd0, ack | err}, 32'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic oob;
      logic [31:0] v;
      idle_bus();
      adr = 0; wdat = 0; sel = 0;
      rst_n = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ack", {31'd0, ack}, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      chk("rst_dat", rdat, 32'd0);
      for (int i = 0; i < 8192; i++) begin
         v = $urandom;
         dut.ram0.mem[i] = v;
         mdl[i] = v;
      end
      @(posedge clk); #1 rst_n = 1;
      @(posedge clk); #1;

      // Classic write then read.
      classic(32'h100, 1, 32'hDEAD_BEEF, 4'hF);
      classic(32'h100, 0, 32'h0, 4'hF);

      // Byte lanes and empty select.
      dut.ram0.mem[32'h300 >> 2] = 32'h1122_3344;
      mdl[32'h300 >> 2] = 32'h1122_3344;
      classic(32'h300, 1, 32'h0000_00AA, 4'b0001);
      classic(32'h300, 0, 32'h0, 4'hF);
      classic(32'h300, 1, 32'hFFFF_FFFF, 4'b0000);
      classic(32'h300, 0, 32'h0, 4'hF);
      classic(32'h300, 1, 32'h5500_6600, 4'b1010);
      classic(32'h300, 0, 32'h0, 4'hF);

      // Wrap4 from 0x18 over words 1..4 -> 3,4,1,2.
      for (int i = 0; i < 4; i++) begin
         dut.ram0.mem[4 + i] = i + 1;
         mdl[4 + i] = i + 1;
      end
      burst(32'h18, BTE_WRAP4, 4, 0, 0, 4'hF, -1, 0);
      burst(32'h38, BTE_WRAP8, 8, 0, 0, 4'hF, -1, 0);
      burst(32'h7C, BTE_WRAP16, 16, 0, 0, 4'hF, -1, 0);

      // Linear read with a 2-cycle stb gap after beat 2.
      burst(32'h400, BTE_LINEAR, 4, 0, 0, 4'hF, 2, 2);

      // Linear and wrap write bursts, read back.
      burst(32'h500, BTE_LINEAR, 4, 1, 32'hA0A0_0000, 4'hF, -1, 0);
      burst(32'h500, BTE_LINEAR, 4, 0, 0, 4'hF, -1, 0);
      burst(32'h614, BTE_WRAP4, 4, 1, 32'h0B0B_0000, 4'b0110, 1, 1);
      burst(32'h610, BTE_LINEAR, 4, 0, 0, 4'hF, -1, 0);

      // Out of range: classic read/write err, memory unchanged.
      classic(MSZ, 0, 32'h0, 4'hF);
      classic(MSZ, 1, 32'h1234_5678, 4'hF);
      classic(32'h0, 0, 32'h0, 4'hF);
      burst(MSZ - 8, BTE_LINEAR, 4, 0, 0, 4'hF, -1, 0);
      classic(MSZ - 4, 0, 32'h0, 4'hF);

      // Reset during beat 2 of a write burst.
      dut.ram0.mem[32'h200 >> 2] = 32'h5555_5555;
      dut.ram0.mem[32'h204 >> 2] = 32'h6666_6666;
      mdl[32'h200 >> 2] = 32'h5555_5555;
      mdl[32'h204 >> 2] = 32'h6666_6666;
      push_beat(32'h200, 1, 32'hCAFE_0001, 4'hF, oob);
      cyc = 1; stb = 1; we = 1; adr = 32'h200; wdat = 32'hCAFE_0001; sel = 4'hF;
      cti = CTI_INC; bte = BTE_LINEAR;
      @(posedge clk); #1;
      @(posedge clk); #1;
      wdat = 32'hCAFE_0002;
      #1 chk("rst_pre_ack", {31'd0, ack}, 32'd1);
      rst_n = 0;
      #1 begin
         chk("rst_async_ack", {31'd0, ack}, 32'd0);
         chk("rst_async_err", {31'd0, err}, 32'd0);
         chk("rst_async_dat", rdat, 32'd0);
      end
      idle_bus();
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
      chk("rst_b1_kept", dut.ram0.mem[32'h200 >> 2], 32'hCAFE_0001);
      chk("rst_b2_untouched", dut.ram0.mem[32'h204 >> 2], 32'h6666_6666);
      @(posedge clk); #1;
      classic(32'h200, 0, 32'h0, 4'hF);
      classic(32'h204, 0, 32'h0, 4'hF);

      repeat (2) @(posedge clk);
      chk("sb_empty", sbq.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", nerr, ncheck);
      $finish;
   end

endmodule
